voice_scheduler: RTL and testbench
==================================

VOICE_SCHEDULER -- requirements
Module: voice_scheduler

Interface
REQ-001 Parameter NVOICE, default 4: number of voice generators sharing the sample bus.
REQ-002 Parameter SW, default 16: signed sample width.
REQ-003 Parameter TIMEOUT, default 15: max cycles to wait for a voice ack.
REQ-004 clk  input  1  system clock, 100 MHz.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 frame_start  input  1  one-cycle pulse from the I2S transmitter, once per lrck period.
REQ-007 voice_en  input  NVOICE  per-voice enable; sampled at frame_start.
REQ-008 req  output  NVOICE  one-hot sample request to voice i.
REQ-009 ack  input  NVOICE  per-voice acknowledge; sample_in valid in the cycle ack[i] is high with req[i].
REQ-010 sample_in  input  SW  shared signed sample bus from voices.
REQ-011 out_sample  output  SW  mixed, saturated sample to the I2S transmitter.
REQ-012 out_valid  output  1  out_sample valid.
REQ-013 out_ready  input  1  transmitter accepts out_sample.
REQ-014 err_timeout  output  1  sticky: a voice failed to ack within TIMEOUT.
REQ-015 err_overrun  output  1  sticky: frame_start arrived while not IDLE.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states: IDLE, REQ, OUT; only IDLE accepts frame_start.
REQ-018 IDLE + frame_start: latch voice_en into en_q, clear accumulator, set index to lowest enabled voice, go to REQ next cycle; if en_q is zero, go to OUT with sum 0.
REQ-019 REQ: assert only req[index]; hold it until ack[index] or TIMEOUT cycles elapsed.
REQ-020 On ack[index] & req[index]: add sign-extended sample_in to accumulator in the same edge; drop req next cycle.
REQ-021 On timeout: add 0, set err_timeout, drop req.
REQ-022 After each voice: advance to next higher enabled index in REQ; after the highest enabled voice go to OUT; disabled voices take zero cycles.
REQ-023 Accumulator width SW+clog2(NVOICE); no overflow inside accumulator.
REQ-024 Entering OUT: out_sample = accumulator saturated to [-2^(SW-1), 2^(SW-1)-1]; out_valid high.
REQ-025 OUT: out_sample, out_valid stable until out_ready; the handshake cycle returns to IDLE, out_valid low next cycle.
REQ-026 Latency with ack tied high: frame_start at T -> req one-hot at T+1..T+NVOICE -> out_valid at T+NVOICE+1.
REQ-027 frame_start while busy: ignored, err_overrun set, current frame completes unchanged.
REQ-028 ack on a non-requested voice, or ack outside REQ: ignored.
REQ-029 frame_start and out_ready handshake in the same cycle: handshake completes, frame_start counts as overrun (FSM not yet IDLE).
REQ-030 Sticky errors clear only on rst.

Reset
REQ-031 rst high asynchronously forces IDLE, req=0, out_valid=0, out_sample=0, accumulator=0, timeout counter=0, err_timeout=0, err_overrun=0, busy=0.
REQ-032 Reset mid-frame aborts the frame with no output; first frame_start after rst release starts a clean frame.

Structure
REQ-033 FSM state encoding and a saturate width helper constant in shared package synth_pkg.
REQ-034 One sub-module natural: sat_clip (accumulator -> SW-bit saturation, combinational).
REQ-035 Single clock domain; no internal clock division; TIMEOUT counter width clog2(TIMEOUT+1).

Verification
REQ-036 All voices enabled, ack tied high, samples 100,200,-50,7 -> out_sample=257, out_valid at T+5.
REQ-037 Samples 32767 x4 -> out_sample=32767; samples -32768 x4 -> -32768.
REQ-038 voice_en=4'b0101, samples 10,20,30,40 -> req only on voices 0,2; out_sample=40, out_valid at T+3.
REQ-039 Voice 1 never acks -> req[1] drops after 15 cycles, err_timeout=1, out_sample=sum of voices 0,2,3.
REQ-040 out_ready low 20 cycles, second frame_start during wait -> out_sample stable, err_overrun=1, one output only.
REQ-041 rst pulse while req[2] high -> all outputs zero immediately; next frame yields correct sum.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared definitions for the voice scheduler.
//   vs_state_t     : scheduler FSM state encoding (IDLE / REQ / OUT)
//   sat_acc_width  : accumulator width that holds NVOICE summed SW-bit samples
//                    without overflow; saturation reduces it back to SW bits
package synth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_OUT  = 2'd2
    } vs_state_t;

    function automatic int sat_acc_width(input int sw, input int nvoice);
        return sw + $clog2(nvoice);
    endfunction

endpackage

// File: rtl/voice_scheduler_if.sv
// Bus between the voice scheduler, the voice generators and the I2S transmitter.
//   frame_start  : one-cycle frame pulse from the transmitter
//   voice_en     : per-voice enable, sampled on an accepted frame_start
//   req / ack    : one-hot sample request to voice i, acknowledge from voice i;
//                  sample_in is valid in the cycle ack[i] is high with req[i]
//   out_sample / out_valid / out_ready : mixed sample to the transmitter
//   err_timeout / err_overrun : sticky error flags
//   busy         : scheduler is not IDLE
//   dbg_state    : current FSM state
// Output handshake: out_sample is held stable while out_valid is high and
// out_ready is low; a transfer happens in the cycle both are high.
// master = scheduler side, slave = environment side.
interface voice_scheduler_if
    import synth_pkg::*;
#(
    parameter int NVOICE = 4,
    parameter int SW     = 16
) ();
    logic              frame_start;
    logic [NVOICE-1:0] voice_en;
    logic [NVOICE-1:0] req;
    logic [NVOICE-1:0] ack;
    logic [SW-1:0]     sample_in;
    logic [SW-1:0]     out_sample;
    logic              out_valid;
    logic              out_ready;
    logic              err_timeout;
    logic              err_overrun;
    logic              busy;
    vs_state_t         dbg_state;

    modport master (
        input  frame_start, voice_en, ack, sample_in, out_ready,
        output req, out_sample, out_valid, err_timeout, err_overrun, busy, dbg_state
    );

    modport slave (
        output frame_start, voice_en, ack, sample_in, out_ready,
        input  req, out_sample, out_valid, err_timeout, err_overrun, busy, dbg_state
    );
endinterface

// File: rtl/voice_scheduler_sat_clip.sv
// Combinational saturation of a signed AW-bit accumulator to a signed SW-bit
// sample in [-2^(SW-1), 2^(SW-1)-1].
//   i_acc    : signed accumulator value
//   o_sample : saturated sample
module voice_scheduler_sat_clip #(
    parameter int AW = 18,
    parameter int SW = 16
) (
    input  logic signed [AW-1:0] i_acc,
    output logic        [SW-1:0] o_sample
);
    localparam logic signed [AW-1:0] MAXV = {{(AW-SW+1){1'b0}}, {(SW-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = ~MAXV;

    always_comb begin
        o_sample = i_acc[SW-1:0];
        if (i_acc > MAXV) begin
            o_sample = MAXV[SW-1:0];
        end else if (i_acc < MINV) begin
            o_sample = MINV[SW-1:0];
        end
    end
endmodule

// File: rtl/voice_scheduler.sv
// Voice scheduler: on each frame pulse, polls every enabled voice in ascending
// index order for one sample, sums them, saturates the sum and presents it to
// the I2S transmitter with a valid/ready handshake.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : voice_scheduler_if master modport (see interface file)
module voice_scheduler
    import synth_pkg::*;
#(
    parameter int NVOICE  = 4,
    parameter int SW      = 16,
    parameter int TIMEOUT = 15
) (
    input logic               clk,
    input logic               rst,
    voice_scheduler_if.master bus
);
    localparam int AW = sat_acc_width(SW, NVOICE);
    localparam int IW = (NVOICE > 1) ? $clog2(NVOICE) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    vs_state_t            r_state;
    logic [NVOICE-1:0]    r_en_q;
    logic [IW-1:0]        r_idx;
    logic [NVOICE-1:0]    r_req;
    logic signed [AW-1:0] r_acc;
    logic [CW-1:0]        r_to_cnt;
    logic [SW-1:0]        r_out_sample;
    logic                 r_out_valid;
    logic                 r_err_to;
    logic                 r_err_ov;

    logic signed [AW-1:0] w_sample_ext;
    logic signed [AW-1:0] w_acc_next;
    logic                 w_ack_hit;
    logic                 w_timeout;
    logic [IW-1:0]        w_first_idx;
    logic [IW-1:0]        w_next_idx;
    logic                 w_has_next;
    logic [SW-1:0]        w_sat;

    // Lowest enabled voice of the incoming mask, and next higher enabled voice
    // after the current one. Descending loops let the lowest match win.
    always_comb begin
        w_first_idx = '0;
        for (int i = NVOICE - 1; i >= 0; i--) begin
            if (bus.voice_en[i]) begin
                w_first_idx = IW'(i);
            end
        end
        w_next_idx = '0;
        w_has_next = 1'b0;
        for (int i = NVOICE - 1; i >= 0; i--) begin
            if (r_en_q[i] && (IW'(i) > r_idx)) begin
                w_next_idx = IW'(i);
                w_has_next = 1'b1;
            end
        end
    end

    assign w_sample_ext = AW'($signed(bus.sample_in));
    assign w_ack_hit    = (r_state == ST_REQ) && bus.ack[r_idx] && r_req[r_idx];
    // An ack on the final cycle wins over the timeout.
    assign w_timeout    = (r_state == ST_REQ) && !w_ack_hit && (r_to_cnt == TO_LAST);
    // Sum including the sample accepted this edge, so the last voice's sample
    // reaches the saturated output in the same edge that enters OUT.
    assign w_acc_next   = w_ack_hit ? (r_acc + w_sample_ext) : r_acc;

    voice_scheduler_sat_clip #(
        .AW (AW),
        .SW (SW)
    ) u_sat_clip (
        .i_acc    (w_acc_next),
        .o_sample (w_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_en_q       <= '0;
            r_idx        <= '0;
            r_req        <= '0;
            r_acc        <= '0;
            r_to_cnt     <= '0;
            r_out_sample <= '0;
            r_out_valid  <= 1'b0;
            r_err_to     <= 1'b0;
            r_err_ov     <= 1'b0;
        end else begin
            // Includes the OUT handshake cycle: the FSM is not yet IDLE there.
            if (bus.frame_start && (r_state != ST_IDLE)) begin
                r_err_ov <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (bus.frame_start) begin
                        r_en_q   <= bus.voice_en;
                        r_acc    <= '0;
                        r_idx    <= w_first_idx;
                        r_to_cnt <= '0;
                        if (bus.voice_en == '0) begin
                            r_state      <= ST_OUT;
                            r_out_sample <= '0;
                            r_out_valid  <= 1'b1;
                        end else begin
                            r_state <= ST_REQ;
                            r_req   <= NVOICE'(1) << w_first_idx;
                        end
                    end
                end
                ST_REQ: begin
                    if (w_ack_hit || w_timeout) begin
                        r_acc    <= w_acc_next;
                        r_to_cnt <= '0;
                        if (w_timeout) begin
                            r_err_to <= 1'b1;
                        end
                        if (w_has_next) begin
                            r_idx <= w_next_idx;
                            r_req <= NVOICE'(1) << w_next_idx;
                        end else begin
                            r_req        <= '0;
                            r_state      <= ST_OUT;
                            r_out_sample <= w_sat;
                            r_out_valid  <= 1'b1;
                        end
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req         = r_req;
    assign bus.out_sample  = r_out_sample;
    assign bus.out_valid   = r_out_valid;
    assign bus.err_timeout = r_err_to;
    assign bus.err_overrun = r_err_ov;
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.dbg_state   = r_state;
endmodule

// File: tb/tb_voice_scheduler.sv
module tb_voice_scheduler;
    localparam int NVOICE  = 4;
    localparam int SW      = 16;
    localparam int TIMEOUT = 15;
    localparam int SMAX    = (1 << (SW - 1)) - 1;
    localparam int SMIN    = -(1 << (SW - 1));

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    voice_scheduler_if #(.NVOICE(NVOICE), .SW(SW)) vif ();

    voice_scheduler #(
        .NVOICE  (NVOICE),
        .SW      (SW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    // ---------------- shared state ----------------
    int                     total = 0;
    int                     bad   = 0;
    logic [SW-1:0]          exp_q[$];
    logic signed [SW-1:0]   samp [NVOICE];
    logic [NVOICE-1:0]      hang_mask = '0;
    logic [NVOICE-1:0]      cur_en    = '0;
    int                     ack_mode  = 0;   // 0: ack tied high, 1: random ack delay
    int                     rdy_mode  = 0;   // 0: always, 1: random, 2: hold low, 3: manual
    int                     rdy_hold  = 0;
    bit                     man_rdy   = 1'b0;
    bit                     in_frame  = 1'b0;
    bit                     exp_to    = 1'b0;
    bit                     exp_ov    = 1'b0;
    bit                     mon_en    = 1'b0;
    int                     exp_lat   = -1;
    int                     t_fs      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // ---------------- voice generators ----------------
    logic [NVOICE-1:0] seen_req = '0;
    int                wcnt = 0;
    int                dly  = 0;

    initial begin
        vif.ack       = '0;
        vif.sample_in = '0;
        forever begin
            @(posedge clk);
            #2;
            if (vif.req != seen_req) begin
                seen_req = vif.req;
                wcnt     = 0;
                dly      = $urandom_range(0, 3);
            end
            vif.sample_in = SW'($urandom);
            if (ack_mode == 0) begin
                vif.ack = ~hang_mask;
                for (int i = 0; i < NVOICE; i++) begin
                    if (vif.req[i]) vif.sample_in = samp[i];
                end
            end else begin
                vif.ack = NVOICE'($urandom) & ~vif.req;
                for (int i = 0; i < NVOICE; i++) begin
                    if (vif.req[i] && !hang_mask[i]) begin
                        if (wcnt >= dly) begin
                            vif.ack[i]    = 1'b1;
                            vif.sample_in = samp[i];
                        end else begin
                            wcnt++;
                        end
                    end
                end
            end
        end
    end

    // ---------------- transmitter ready ----------------
    int vcnt = 0;

    initial begin
        vif.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0: vif.out_ready = 1'b1;
                1: vif.out_ready = ($urandom_range(0, 2) != 0);
                2: begin
                    if (vif.out_valid) begin
                        if (vcnt >= rdy_hold) begin
                            vif.out_ready = 1'b1;
                        end else begin
                            vif.out_ready = 1'b0;
                            vcnt++;
                        end
                    end else begin
                        vif.out_ready = 1'b0;
                        vcnt = 0;
                    end
                end
                default: vif.out_ready = man_rdy;
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [NVOICE-1:0] m_prev_req = '0;
    int                run = 0;
    bit                prev_valid = 1'b0;
    bit                prev_hs = 1'b0;

    always @(negedge clk) begin
        if (rst || !mon_en) begin
            m_prev_req = '0;
            run        = 0;
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (prev_hs) begin
                check("valid_drop_after_hs", vif.out_valid, 0);
                check("idle_after_hs", vif.busy, 0);
            end
            if (vif.req != '0) begin
                check("req_onehot", $onehot(vif.req), 1);
                check("req_enabled_only", vif.req & ~cur_en, 0);
            end
            if (vif.req != m_prev_req) begin
                if ((m_prev_req & hang_mask) != '0) check("timeout_len", run, TIMEOUT);
                run        = (vif.req != '0) ? 1 : 0;
                m_prev_req = vif.req;
            end else if (vif.req != '0) begin
                run++;
            end
            if (vif.out_valid && !prev_valid && exp_lat >= 0) begin
                check("latency", cyc - t_fs, exp_lat);
            end
            if (exp_q.size() == 0) begin
                check("spurious_valid", vif.out_valid, 0);
            end else if (vif.out_valid) begin
                check("out_hold", vif.out_sample, exp_q[0]);
            end
            if (vif.out_valid && vif.out_ready) begin
                if (exp_q.size() > 0) check("sample", vif.out_sample, exp_q.pop_front());
                in_frame = 1'b0;
            end
            prev_hs    = vif.out_valid && vif.out_ready;
            prev_valid = vif.out_valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        #1 rst = 1'b1;
        #1;
        check("rst_req", vif.req, 0);
        check("rst_out_valid", vif.out_valid, 0);
        check("rst_out_sample", vif.out_sample, 0);
        check("rst_busy", vif.busy, 0);
        check("rst_err_timeout", vif.err_timeout, 0);
        check("rst_err_overrun", vif.err_overrun, 0);
        exp_q.delete();
        in_frame = 1'b0;
        exp_to   = 1'b0;
        exp_ov   = 1'b0;
        exp_lat  = -1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    // Reference: sum of every enabled voice that answers, clipped to SW bits;
    // with ack tied high each enabled voice costs one cycle.
    task automatic run_frame(input logic [NVOICE-1:0] en, input logic [NVOICE-1:0] hang,
                             input int mode);
        int sum = 0;
        int n   = 0;
        for (int i = 0; i < NVOICE; i++) begin
            if (en[i]) begin
                n++;
                if (!hang[i]) sum += int'(samp[i]);
            end
        end
        if (sum > SMAX) sum = SMAX;
        if (sum < SMIN) sum = SMIN;
        ack_mode  = mode;
        hang_mask = hang;
        cur_en    = en;
        exp_q.push_back(SW'(sum));
        if ((en & hang) != '0) exp_to = 1'b1;
        exp_lat = (mode == 0 && (en & hang) == '0) ? n + 1 : -1;
        @(posedge clk);
        #2;
        vif.voice_en    = en;
        vif.frame_start = 1'b1;
        t_fs            = cyc;
        in_frame        = 1'b1;
        @(posedge clk);
        #2;
        vif.frame_start = 1'b0;
        vif.voice_en    = NVOICE'($urandom);
    endtask

    task automatic pulse_frame_start();
        @(posedge clk);
        #2;
        if (in_frame) exp_ov = 1'b1;
        vif.frame_start = 1'b1;
        @(posedge clk);
        #2;
        vif.frame_start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int k = 0;
        while (in_frame && k < limit) begin
            @(negedge clk);
            k++;
        end
        check("frame_done", in_frame, 0);
        if (in_frame) begin
            apply_reset();
        end else begin
            @(negedge clk);
            check("err_timeout", vif.err_timeout, exp_to);
            check("err_overrun", vif.err_overrun, exp_ov);
            check("busy_idle", vif.busy, 0);
        end
    endtask

    task automatic set_samples(input int s0, input int s1, input int s2, input int s3);
        samp[0] = SW'(s0);
        samp[1] = SW'(s1);
        samp[2] = SW'(s2);
        samp[3] = SW'(s3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int k;
        vif.frame_start = 1'b0;
        vif.voice_en    = '0;
        set_samples(0, 0, 0, 0);
        apply_reset();
        mon_en = 1'b1;

        // All voices, ack tied high
        set_samples(100, 200, -50, 7);
        run_frame(4'hF, 4'h0, 0);
        wait_done(50);

        // Saturation at both rails
        set_samples(SMAX, SMAX, SMAX, SMAX);
        run_frame(4'hF, 4'h0, 0);
        wait_done(50);
        set_samples(SMIN, SMIN, SMIN, SMIN);
        run_frame(4'hF, 4'h0, 0);
        wait_done(50);

        // Sparse enable mask; disabled voices skipped
        set_samples(10, 20, 30, 40);
        run_frame(4'b0101, 4'h0, 0);
        wait_done(50);

        // No voices enabled
        run_frame(4'h0, 4'h0, 0);
        wait_done(50);

        // Voice 1 never acks
        set_samples(11, 22, 33, 44);
        run_frame(4'hF, 4'b0010, 1);
        wait_done(100);

        // Transmitter stalls 20 cycles; extra frame_start while waiting
        rdy_mode = 2;
        rdy_hold = 20;
        set_samples(1000, -3, 250, -4000);
        run_frame(4'hF, 4'h0, 0);
        repeat (8) @(negedge clk);
        pulse_frame_start();
        wait_done(100);
        repeat (5) @(negedge clk);

        // frame_start coincident with the output handshake
        rdy_mode = 3;
        man_rdy  = 1'b0;
        set_samples(-7, 8, -9, 10);
        run_frame(4'b1011, 4'h0, 0);
        k = 0;
        while (!vif.out_valid && k < 30) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        man_rdy = 1'b1;
        pulse_frame_start();
        man_rdy = 1'b0;
        wait_done(50);
        rdy_mode = 0;
        set_samples(5, 6, 7, 8);
        run_frame(4'b1100, 4'h0, 0);
        wait_done(50);

        // Randomized frames
        rdy_mode = 1;
        for (int f = 0; f < 40; f++) begin
            logic [NVOICE-1:0] en;
            logic [NVOICE-1:0] hg;
            en = NVOICE'($urandom);
            hg = '0;
            if ($urandom_range(0, 7) == 0) hg[$urandom_range(0, NVOICE - 1)] = 1'b1;
            for (int i = 0; i < NVOICE; i++) begin
                case ($urandom_range(0, 3))
                    0:       samp[i] = SW'(SMAX);
                    1:       samp[i] = SW'(SMIN);
                    default: samp[i] = SW'($urandom);
                endcase
            end
            run_frame(en, hg, int'($urandom_range(0, 1)));
            wait_done(200);
        end

        // Reset while voice 2 is being requested, then a clean frame
        rdy_mode = 0;
        set_samples(1, 2, 3, 4);
        run_frame(4'hF, 4'h0, 0);
        k = 0;
        while (!vif.req[2] && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("saw_req2", vif.req[2], 1);
        apply_reset();
        set_samples(-100, 300, 50, 1);
        run_frame(4'hF, 4'h0, 0);
        wait_done(50);

        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
